// File: rtl/race_defs_pkg.sv
// rtl/race_defs_pkg.sv - shared race definitions for gearbox, HUD and velocity blocks
// Purpose: state encoding, gear/rpm widths, default rpm limits and the
//          upshift rpm-drop helper.
// Ports:   none (package)
package race_defs;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    DRIVE  = 2'd1,
    SHIFT  = 2'd2,
    FINISH = 2'd3
  } race_state_t;

  localparam int GEAR_COUNT       = 4;
  localparam int GEAR_W           = 2;
  localparam int RPM_W            = 14;
  localparam int RPM_IDLE_DEFAULT = 1000;
  localparam int RPM_MAX_DEFAULT  = 9000;

  // Engine speed after an upshift: lose a quarter of the revs, never below idle.
  function automatic logic [RPM_W-1:0] shift_drop(input logic [RPM_W-1:0] rpm,
                                                  input logic [RPM_W-1:0] floor_rpm);
    logic [RPM_W-1:0] dropped;
    dropped = rpm - (rpm >> 2);
    return (dropped < floor_rpm) ? floor_rpm : dropped;
  endfunction

endpackage

// File: rtl/rpm_integrator.sv
// rtl/rpm_integrator.sv - saturating engine rpm accumulator with load port
// Purpose: holds engine rpm; each enabled tick adds or removes a step and
//          clamps to [floor, ceiling]. A load overrides the step.
// Ports:
//   clk100Hz      in   tick clock
//   rst           in   synchronous active-high clear to RESET_RPM
//   i_enable      in   apply the step this tick
//   i_up          in   1 = add step, 0 = remove step
//   i_step        in   step size
//   i_floor       in   lower clamp
//   i_ceiling     in   upper clamp
//   i_load        in   replace rpm with i_load_value (wins over i_enable)
//   i_load_value  in   value for i_load
//   o_rpm         out  registered rpm
//   o_rpm_next    out  value o_rpm takes on the next edge (excluding rst)
module rpm_integrator
  import race_defs::*;
#(
  parameter logic [RPM_W-1:0] RESET_RPM = RPM_W'(RPM_IDLE_DEFAULT)
) (
  input  logic             clk100Hz,
  input  logic             rst,
  input  logic             i_enable,
  input  logic             i_up,
  input  logic [RPM_W-1:0] i_step,
  input  logic [RPM_W-1:0] i_floor,
  input  logic [RPM_W-1:0] i_ceiling,
  input  logic             i_load,
  input  logic [RPM_W-1:0] i_load_value,
  output logic [RPM_W-1:0] o_rpm,
  output logic [RPM_W-1:0] o_rpm_next
);

  logic [RPM_W-1:0] r_rpm;
  logic [RPM_W:0]   w_sum;
  logic [RPM_W:0]   w_diff;
  logic [RPM_W-1:0] w_rpm_next;

  // One extra bit so overflow above the ceiling and underflow below zero
  // are both visible before clamping.
  always_comb begin
    w_sum      = {1'b0, r_rpm} + {1'b0, i_step};
    w_diff     = {1'b0, r_rpm} - {1'b0, i_step};
    w_rpm_next = r_rpm;
    if (i_load) begin
      w_rpm_next = i_load_value;
    end else if (i_enable) begin
      if (i_up) begin
        w_rpm_next = (w_sum > {1'b0, i_ceiling}) ? i_ceiling : w_sum[RPM_W-1:0];
      end else begin
        w_rpm_next = (w_diff[RPM_W] || (w_diff[RPM_W-1:0] < i_floor)) ? i_floor
                                                                        : w_diff[RPM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk100Hz) begin
    if (rst) begin
      r_rpm <= RESET_RPM;
    end else begin
      r_rpm <= w_rpm_next;
    end
  end

  assign o_rpm      = r_rpm;
  assign o_rpm_next = w_rpm_next;

endmodule

// File: rtl/gearbox_controller.sv
// rtl/gearbox_controller.sv - engine and gearbox sequencer for one drag race
// Purpose: per 100 Hz tick, produces engine rpm and selected gear through the
//          ARMED -> DRIVE <-> SHIFT -> FINISH race sequence.
// Ports:
//   clk100Hz         in   tick clock
//   rst              in   synchronous active-high reset
//   i_reset_status   in   race restart, same effect as rst
//   i_throttle       in   throttle pressed (level)
//   i_shift_up       in   upshift request (pulse)
//   i_race_start     in   start light (pulse)
//   i_race_finish    in   finish line (pulse)
//   o_rpm_tach       out  engine rpm for display
//   o_rpm_drive      out  rpm to velocity datapath, 0 outside DRIVE
//   o_gear           out  selected gear 0..3
//   o_shifting       out  high during SHIFT
//   o_perfect_shift  out  one-tick pulse for an upshift inside the window
//   o_over_rev       out  high while rpm is at the limiter
//   o_finished       out  high in FINISH
module gearbox_controller
  import race_defs::*;
#(
  parameter int RPM_IDLE     = RPM_IDLE_DEFAULT,
  parameter int RPM_MAX      = RPM_MAX_DEFAULT,
  parameter int RPM_SHIFT_LO = 7000,
  parameter int RPM_RISE     = 120,
  parameter int RPM_FALL     = 60,
  parameter int SHIFT_TICKS  = 20
) (
  input  logic              clk100Hz,
  input  logic              rst,
  input  logic              i_reset_status,
  input  logic              i_throttle,
  input  logic              i_shift_up,
  input  logic              i_race_start,
  input  logic              i_race_finish,
  output logic [RPM_W-1:0]  o_rpm_tach,
  output logic [RPM_W-1:0]  o_rpm_drive,
  output logic [GEAR_W-1:0] o_gear,
  output logic              o_shifting,
  output logic              o_perfect_shift,
  output logic              o_over_rev,
  output logic              o_finished
);

  localparam int CNT_W = (SHIFT_TICKS > 2) ? $clog2(SHIFT_TICKS) : 1;

  localparam logic [RPM_W-1:0]  L_IDLE     = RPM_W'(RPM_IDLE);
  localparam logic [RPM_W-1:0]  L_MAX      = RPM_W'(RPM_MAX);
  localparam logic [RPM_W-1:0]  L_SHIFT_LO = RPM_W'(RPM_SHIFT_LO);
  localparam logic [RPM_W-1:0]  L_RISE     = RPM_W'(RPM_RISE);
  localparam logic [RPM_W-1:0]  L_FALL     = RPM_W'(RPM_FALL);
  localparam logic [CNT_W-1:0]  L_CNT_LOAD = CNT_W'(SHIFT_TICKS - 1);
  localparam logic [GEAR_W-1:0] L_TOP_GEAR = GEAR_W'(GEAR_COUNT - 1);

  race_state_t       r_state, w_state_next;
  logic [GEAR_W-1:0] r_gear, w_gear_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic              r_perfect, w_perfect_next;
  logic [RPM_W-1:0]  r_rpm_drive;
  logic              r_shifting;
  logic              r_finished;

  logic              w_reset;
  logic [RPM_W-1:0]  w_rpm;
  logic [RPM_W-1:0]  w_rpm_next;
  logic              w_rpm_en;
  logic              w_rpm_up;
  logic              w_rpm_load;
  logic [RPM_W-1:0]  w_step;
  logic [RPM_W-1:0]  w_drop;
  logic              w_in_window;

  assign w_reset     = rst | i_reset_status;
  // Higher gears rise more slowly: halve the rise per gear.
  assign w_step      = w_rpm_up ? (L_RISE >> r_gear) : L_FALL;
  assign w_drop      = shift_drop(w_rpm, L_IDLE);
  // A shift at the limiter itself does not count as perfect.
  assign w_in_window = (w_rpm >= L_SHIFT_LO) && (w_rpm < L_MAX);

  rpm_integrator #(
    .RESET_RPM (L_IDLE)
  ) u_rpm (
    .clk100Hz     (clk100Hz),
    .rst          (w_reset),
    .i_enable     (w_rpm_en),
    .i_up         (w_rpm_up),
    .i_step       (w_step),
    .i_floor      (L_IDLE),
    .i_ceiling    (L_MAX),
    .i_load       (w_rpm_load),
    .i_load_value (w_drop),
    .o_rpm        (w_rpm),
    .o_rpm_next   (w_rpm_next)
  );

  always_ff @(posedge clk100Hz) begin
    if (w_reset) begin
      r_state     <= ARMED;
      r_gear      <= '0;
      r_cnt       <= '0;
      r_perfect   <= 1'b0;
      r_rpm_drive <= '0;
      r_shifting  <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_gear      <= w_gear_next;
      r_cnt       <= w_cnt_next;
      r_perfect   <= w_perfect_next;
      // Driven rpm tracks the tach rpm on the same tick it enters/stays in DRIVE.
      r_rpm_drive <= (w_state_next == DRIVE) ? w_rpm_next : '0;
      r_shifting  <= (w_state_next == SHIFT);
      r_finished  <= (w_state_next == FINISH);
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_gear_next    = r_gear;
    w_cnt_next     = r_cnt;
    w_perfect_next = 1'b0;
    w_rpm_en       = 1'b0;
    w_rpm_up       = 1'b0;
    w_rpm_load     = 1'b0;
    case (r_state)
      ARMED: begin
        w_rpm_en = 1'b1;
        w_rpm_up = i_throttle;
        if (i_race_start) begin
          w_state_next = DRIVE;
        end
      end
      DRIVE: begin
        if (i_race_finish) begin
          w_state_next = FINISH;
          w_rpm_en     = 1'b1;
        end else if (i_shift_up && (r_gear != L_TOP_GEAR)) begin
          // rpm freezes from the acceptance tick: the clutch is opening.
          w_state_next   = SHIFT;
          w_cnt_next     = L_CNT_LOAD;
          w_perfect_next = w_in_window;
        end else begin
          w_rpm_en = 1'b1;
          w_rpm_up = i_throttle;
        end
      end
      SHIFT: begin
        if (i_race_finish) begin
          // Abort: the gear never engaged, so it keeps its old value.
          w_state_next = FINISH;
          w_cnt_next   = '0;
        end else if (r_cnt == '0) begin
          w_state_next = DRIVE;
          w_gear_next  = r_gear + GEAR_W'(1);
          w_rpm_load   = 1'b1;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      FINISH: begin
        w_rpm_en = 1'b1;
      end
      default: begin
        w_state_next = ARMED;
      end
    endcase
  end

  assign o_rpm_tach      = w_rpm;
  assign o_rpm_drive     = r_rpm_drive;
  assign o_gear          = r_gear;
  assign o_shifting      = r_shifting;
  assign o_perfect_shift = r_perfect;
  assign o_over_rev      = (w_rpm == L_MAX);
  assign o_finished      = r_finished;

endmodule
